// File: rtl/seizure_pkg.sv
// Shared types for the seizure core run controller: sequencer states, stage codes
// and small state-classification helpers.
package seizure_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PC_RUN   = 3'd1,
    MCMC_RUN = 3'd2,
    DCTC_RUN = 3'd3,
    DONE     = 3'd4,
    ERROR    = 3'd5
  } seq_state_e;

  localparam logic [1:0] STG_NONE = 2'd0;
  localparam logic [1:0] STG_PC   = 2'd1;
  localparam logic [1:0] STG_MCMC = 2'd2;
  localparam logic [1:0] STG_DCTC = 2'd3;

  function automatic logic [1:0] stage_of(input seq_state_e s);
    logic [1:0] code;
    case (s)
      PC_RUN:   code = STG_PC;
      MCMC_RUN: code = STG_MCMC;
      DCTC_RUN: code = STG_DCTC;
      default:  code = STG_NONE;
    endcase
    return code;
  endfunction

  function automatic logic is_run(input seq_state_e s);
    return (stage_of(s) != STG_NONE);
  endfunction

endpackage

// File: rtl/stage_watchdog.sv
// Per-stage watchdog: counts cycles spent in the current RUN state and flags the
// last permitted cycle so the sequencer can divert to ERROR.
module stage_watchdog
  import seizure_pkg::*;
#(
  parameter int TO_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            enable,
  input  logic [TO_W-1:0] limit,
  output logic            expire
);

  logic [TO_W-1:0] count_r;
  logic [TO_W-1:0] last_s;

  // Expiry fires while the counter sits on the final allowed cycle (limit-1).
  assign last_s = limit - {{(TO_W-1){1'b0}}, 1'b1};
  assign expire = enable & (count_r == last_s);

  // Cycle counter: cleared on stage entry, advanced every cycle in a RUN state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {TO_W{1'b0}};
    end else if (clear) begin
      count_r <= {TO_W{1'b0}};
    end else if (enable) begin
      count_r <= count_r + {{(TO_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/core_stage_sequencer.sv
// Run controller for the seizure core: sequences param_calc -> mcmc -> dctc per EEG
// window with watchdog guarding, abort, continuous mode and prediction latching.
module core_stage_sequencer
  import seizure_pkg::*;
#(
  parameter int TO_W         = 16,
  parameter int PC_TIMEOUT   = 4096,
  parameter int MCMC_TIMEOUT = 16384,
  parameter int DCTC_TIMEOUT = 4096,
  parameter int WIN_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic             continuous,
  input  logic             pc_finish,
  input  logic             mcmc_finish,
  input  logic             dctc_finish,
  input  logic             dctc_pred,
  output logic             start_pc,
  output logic             start_mcmc,
  output logic             start_dctc,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [1:0]       err_stage,
  output logic [2:0]       state,
  output logic             seizure_flag,
  output logic [WIN_W-1:0] window_count
);

  localparam logic [TO_W-1:0] PC_LIMIT   = PC_TIMEOUT[TO_W-1:0];
  localparam logic [TO_W-1:0] MCMC_LIMIT = MCMC_TIMEOUT[TO_W-1:0];
  localparam logic [TO_W-1:0] DCTC_LIMIT = DCTC_TIMEOUT[TO_W-1:0];

  seq_state_e       state_r;
  seq_state_e       next_state_s;
  logic             start_pc_r;
  logic             start_mcmc_r;
  logic             start_dctc_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic [1:0]       err_stage_r;
  logic [1:0]       err_stage_s;
  logic             seizure_flag_r;
  logic [WIN_W-1:0] window_count_r;
  logic [TO_W-1:0]  limit_s;
  logic             expire_s;
  logic             run_s;
  logic             wd_clear_s;
  logic             win_done_s;

  // Next-state selection; abort overrides everything, finish beats timeout.
  always_comb begin
    next_state_s = state_r;
    if (abort) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, ERROR: begin
          if (start) next_state_s = PC_RUN;
          else       next_state_s = state_r;
        end
        PC_RUN: begin
          if (pc_finish)     next_state_s = MCMC_RUN;
          else if (expire_s) next_state_s = ERROR;
          else               next_state_s = state_r;
        end
        MCMC_RUN: begin
          if (mcmc_finish)   next_state_s = DCTC_RUN;
          else if (expire_s) next_state_s = ERROR;
          else               next_state_s = state_r;
        end
        DCTC_RUN: begin
          if (dctc_finish)   next_state_s = DONE;
          else if (expire_s) next_state_s = ERROR;
          else               next_state_s = state_r;
        end
        DONE: begin
          if (continuous) next_state_s = PC_RUN;
          else            next_state_s = IDLE;
        end
        default: next_state_s = IDLE;
      endcase
    end
  end

  // Watchdog limit and control derived from the current state.
  always_comb begin
    limit_s = PC_LIMIT;
    case (state_r)
      PC_RUN:   limit_s = PC_LIMIT;
      MCMC_RUN: limit_s = MCMC_LIMIT;
      DCTC_RUN: limit_s = DCTC_LIMIT;
      default:  limit_s = PC_LIMIT;
    endcase
    run_s      = is_run(state_r);
    wd_clear_s = (next_state_s != state_r) | ~run_s;
    win_done_s = (state_r == DCTC_RUN) & (next_state_s == DONE);
  end

  // Error stage is captured on ERROR entry, held in ERROR, cleared on any exit.
  always_comb begin
    err_stage_s = STG_NONE;
    if (next_state_s == ERROR) begin
      if (state_r == ERROR) err_stage_s = err_stage_r;
      else                  err_stage_s = stage_of(state_r);
    end else begin
      err_stage_s = STG_NONE;
    end
  end

  stage_watchdog #(
    .TO_W (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (wd_clear_s),
    .enable  (run_s),
    .limit   (limit_s),
    .expire  (expire_s)
  );

  // State register and all registered outputs, computed from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      start_pc_r     <= 1'b0;
      start_mcmc_r   <= 1'b0;
      start_dctc_r   <= 1'b0;
      busy_r         <= 1'b0;
      done_r         <= 1'b0;
      error_r        <= 1'b0;
      err_stage_r    <= STG_NONE;
      seizure_flag_r <= 1'b0;
      window_count_r <= {WIN_W{1'b0}};
    end else begin
      state_r      <= next_state_s;
      start_pc_r   <= (next_state_s == PC_RUN)   & (state_r != PC_RUN);
      start_mcmc_r <= (next_state_s == MCMC_RUN) & (state_r != MCMC_RUN);
      start_dctc_r <= (next_state_s == DCTC_RUN) & (state_r != DCTC_RUN);
      busy_r       <= is_run(next_state_s) | (next_state_s == DONE);
      done_r       <= (next_state_s == DONE);
      error_r      <= (next_state_s == ERROR);
      err_stage_r  <= err_stage_s;
      if (win_done_s) begin
        seizure_flag_r <= dctc_pred;
        window_count_r <= window_count_r + {{(WIN_W-1){1'b0}}, 1'b1};
      end else begin
        seizure_flag_r <= seizure_flag_r;
        window_count_r <= window_count_r;
      end
    end
  end

  assign state        = state_r;
  assign start_pc     = start_pc_r;
  assign start_mcmc   = start_mcmc_r;
  assign start_dctc   = start_dctc_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign error        = error_r;
  assign err_stage    = err_stage_r;
  assign seizure_flag = seizure_flag_r;
  assign window_count = window_count_r;

endmodule

// File: tb/tb_core_stage_sequencer.sv
// Directed self-checking bench for core_stage_sequencer: a per-cycle vector table
// plus hand-written latency, timeout, wrap and async-reset sequences.
module tb_core_stage_sequencer;

  localparam int PC_T   = 16;
  localparam int MCMC_T = 24;
  localparam int DCTC_T = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       start = 1'b0, abort = 1'b0, continuous = 1'b0;
  logic       pc_finish = 1'b0, mcmc_finish = 1'b0, dctc_finish = 1'b0, dctc_pred = 1'b0;
  logic       start_pc, start_mcmc, start_dctc, busy, done, error, seizure_flag;
  logic [1:0] err_stage;
  logic [2:0] state;
  logic [7:0] window_count;

  int checks = 0;
  int failures = 0;

  core_stage_sequencer #(
    .TO_W(16), .PC_TIMEOUT(PC_T), .MCMC_TIMEOUT(MCMC_T), .DCTC_TIMEOUT(DCTC_T), .WIN_W(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .continuous(continuous),
    .pc_finish(pc_finish), .mcmc_finish(mcmc_finish), .dctc_finish(dctc_finish),
    .dctc_pred(dctc_pred), .start_pc(start_pc), .start_mcmc(start_mcmc),
    .start_dctc(start_dctc), .busy(busy), .done(done), .error(error),
    .err_stage(err_stage), .state(state), .seizure_flag(seizure_flag),
    .window_count(window_count)
  );

  always #5 clk = ~clk;

  // inputs: {start, abort, continuous, pc_finish, mcmc_finish, dctc_finish, dctc_pred}
  typedef struct {
    logic [6:0]  in;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl [24];

  function automatic logic [19:0] mk(input logic spc, input logic smc, input logic sdc,
                                     input logic bsy, input logic dn, input logic er,
                                     input logic [1:0] stg, input logic [2:0] st,
                                     input logic flg, input logic [7:0] wc);
    return {spc, smc, sdc, bsy, dn, er, stg, st, flg, wc};
  endfunction

  function automatic logic [19:0] outs();
    return {start_pc, start_mcmc, start_dctc, busy, done, error, err_stage, state,
            seizure_flag, window_count};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0; abort = 1'b0; pc_finish = 1'b0; mcmc_finish = 1'b0;
    dctc_finish = 1'b0; dctc_pred = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic count_to_error(input int bound, output int n);
    n = 0;
    while (!error && n < bound) begin
      step();
      n++;
    end
  endtask

  int n;
  int dones, misses;
  logic prev_done;

  initial begin
    //            in          spc  smc  sdc  bsy  dn   er   stg   st    flg  wc
    tbl[0]  = '{7'b1000000, mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd1,1'b0,8'd0)};
    tbl[1]  = '{7'b0000000, mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd1,1'b0,8'd0)};
    tbl[2]  = '{7'b0001000, mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,3'd2,1'b0,8'd0)};
    tbl[3]  = '{7'b0000100, mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,3'd3,1'b0,8'd0)};
    tbl[4]  = '{7'b0000011, mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,3'd4,1'b1,8'd1)};
    tbl[5]  = '{7'b0000000, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b1,8'd1)};
    tbl[6]  = '{7'b0001000, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b1,8'd1)};
    tbl[7]  = '{7'b1100000, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b1,8'd1)};
    tbl[8]  = '{7'b1000000, mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd1,1'b1,8'd1)};
    tbl[9]  = '{7'b1000000, mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd1,1'b1,8'd1)};
    tbl[10] = '{7'b0001000, mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,3'd2,1'b1,8'd1)};
    tbl[11] = '{7'b0000010, mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd2,1'b1,8'd1)};
    tbl[12] = '{7'b0100000, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b1,8'd1)};
    tbl[13] = '{7'b0000100, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b1,8'd1)};
    tbl[14] = '{7'b1010000, mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd1,1'b1,8'd1)};
    tbl[15] = '{7'b0011000, mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,3'd2,1'b1,8'd1)};
    tbl[16] = '{7'b0010100, mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,3'd3,1'b1,8'd1)};
    tbl[17] = '{7'b0010010, mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,3'd4,1'b0,8'd2)};
    tbl[18] = '{7'b0010000, mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd1,1'b0,8'd2)};
    tbl[19] = '{7'b0000000, mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,3'd1,1'b0,8'd2)};
    tbl[20] = '{7'b0001000, mk(1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'd0,3'd2,1'b0,8'd2)};
    tbl[21] = '{7'b0000100, mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'd0,3'd3,1'b0,8'd2)};
    tbl[22] = '{7'b0000011, mk(1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'd0,3'd4,1'b1,8'd3)};
    tbl[23] = '{7'b0000000, mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,3'd0,1'b1,8'd3)};

    // reset state, during and after release
    #12;
    chk("reset_outs", {12'd0, outs()}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("reset_idle", {12'd0, outs()}, 32'd0);

    // per-cycle vector table
    for (int i = 0; i < 24; i++) begin
      {start, abort, continuous, pc_finish, mcmc_finish, dctc_finish, dctc_pred} = tbl[i].in;
      step();
      chk($sformatf("vec%0d", i), {12'd0, outs()}, {12'd0, tbl[i].exp});
    end
    continuous = 1'b0;

    // normal run with finish pulses 10/20/5 cycles after each start pulse
    start = 1'b1;
    step();
    chk("norm_start_pc", {29'd0, start_pc, state}, {29'd1, 3'd1});
    step();
    chk("norm_start_pc_drop", {31'd0, start_pc}, 32'd0);
    idle(8);
    pc_finish = 1'b1;
    step();
    chk("norm_start_mcmc", {29'd0, start_mcmc, state}, {29'd1, 3'd2});
    idle(19);
    mcmc_finish = 1'b1;
    step();
    chk("norm_start_dctc", {29'd0, start_dctc, state}, {29'd1, 3'd3});
    idle(4);
    dctc_finish = 1'b1;
    dctc_pred = 1'b0;
    step();
    chk("norm_done", {22'd0, done, seizure_flag, window_count}, {22'd0, 1'b1, 1'b0, 8'd4});
    step();
    chk("norm_idle", {28'd0, done, state}, {28'd0, 1'b0, 3'd0});

    // mcmc timeout: error exactly MCMC_T cycles after start_mcmc
    start = 1'b1;
    step();
    pc_finish = 1'b1;
    step();
    chk("to_mcmc_entry", {31'd0, start_mcmc}, 32'd1);
    count_to_error(100, n);
    chk("to_mcmc_cycles", n, MCMC_T);
    chk("to_mcmc_flags", {26'd0, error, err_stage, state, busy},
        {26'd0, 1'b1, 2'd2, 3'd5, 1'b0});
    start = 1'b1;
    step();
    chk("err_restart", {26'd0, error, err_stage, start_pc, state},
        {26'd0, 1'b0, 2'd0, 1'b1, 3'd1});

    // pc_finish on the final allowed cycle beats the timeout
    idle(PC_T - 1);
    pc_finish = 1'b1;
    step();
    chk("fin_vs_to", {28'd0, error, state}, {28'd0, 1'b0, 3'd2});

    // dctc timeout, then abort out of ERROR
    mcmc_finish = 1'b1;
    step();
    count_to_error(100, n);
    chk("to_dctc_cycles", n, DCTC_T);
    chk("to_dctc_stage", {29'd0, error, err_stage}, {29'd0, 1'b1, 2'd3});
    abort = 1'b1;
    step();
    chk("abort_err", {26'd0, error, err_stage, state}, {26'd0, 1'b0, 2'd0, 3'd0});

    // pc timeout boundary
    start = 1'b1;
    step();
    count_to_error(100, n);
    chk("to_pc_cycles", n, PC_T);
    chk("to_pc_stage", {30'd0, err_stage}, {30'd0, 2'd1});
    abort = 1'b1;
    step();

    // continuous back-to-back windows through the window_count wrap (4 -> 255 -> 0)
    continuous = 1'b1;
    start = 1'b1;
    dones = 0;
    misses = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      pc_finish = 1'b1; mcmc_finish = 1'b1; dctc_finish = 1'b1;
      step();
      if (prev_done && !start_pc) misses++;
      prev_done = done;
      if (done) begin
        dones++;
        if (dones == 251) chk("wrap_255", {24'd0, window_count}, 32'd255);
        if (dones == 252) begin
          chk("wrap_0", {24'd0, window_count}, 32'd0);
          break;
        end
      end
    end
    chk("cont_done_count", dones, 252);
    chk("cont_restart_misses", misses, 0);
    continuous = 1'b0;
    step();
    chk("cont_stop_idle", {28'd0, busy, state}, {28'd0, 1'b0, 3'd0});

    // asynchronous reset in the middle of a run
    start = 1'b1;
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", {12'd0, outs()}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("post_reset_idle", {12'd0, outs()}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
